gpo_ctrl: RTL

//   Parametrised general-purpose output slot core for the MMIO bus. Successor to the

---
 rtl/gpo_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/gpo_ctrl.sv
// General-purpose output slot: W output pins with atomic set/clear/toggle,
// per-bit blink at a programmable rate and a timed one-shot pulse overlay.
module gpo_ctrl #(
    parameter int W  = 8,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          read,
    input  logic          write,
    input  logic [4:0]    addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    output logic [W-1:0]  dout
);

    localparam logic [4:0] ADDR_DATA  = 5'd0;
    localparam logic [4:0] ADDR_SET   = 5'd1;
    localparam logic [4:0] ADDR_CLR   = 5'd2;
    localparam logic [4:0] ADDR_TOG   = 5'd3;
    localparam logic [4:0] ADDR_MODE  = 5'd4;
    localparam logic [4:0] ADDR_DIV   = 5'd5;
    localparam logic [4:0] ADDR_PLEN  = 5'd6;
    localparam logic [4:0] ADDR_PTRIG = 5'd7;
    localparam logic [4:0] ADDR_STAT  = 5'd8;

    logic          wr;
    logic [W-1:0]  wr_bits;
    logic [CW-1:0] wr_cnt;

    logic [W-1:0]  data_reg;
    logic [W-1:0]  mode_reg;
    logic [CW-1:0] div_reg;
    logic [CW-1:0] plen_reg;
    logic [W-1:0]  pmask;
    logic [CW-1:0] pcnt;
    logic [CW-1:0] bcnt;
    logic          phase;
    logic          pulse_busy;
    logic          ptrig_fire;

    // Reads are side-effect free, so the read strobe carries no information here.
    logic unused_ok;
    assign unused_ok = ^{read, wr_data};

    assign wr         = cs && write;
    assign wr_bits    = wr_data[W-1:0];
    assign wr_cnt     = wr_data[CW-1:0];
    assign pulse_busy = (pcnt != '0);
    assign ptrig_fire = wr && (addr == ADDR_PTRIG) && (plen_reg != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg <= '0;
        end else if (wr) begin
            case (addr)
                ADDR_DATA: data_reg <= wr_bits;
                ADDR_SET:  data_reg <= data_reg | wr_bits;
                ADDR_CLR:  data_reg <= data_reg & ~wr_bits;
                ADDR_TOG:  data_reg <= data_reg ^ wr_bits;
                default:   data_reg <= data_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_reg <= '0;
            div_reg  <= '0;
            plen_reg <= '0;
        end else if (wr) begin
            if (addr == ADDR_MODE) mode_reg <= wr_bits;
            if (addr == ADDR_DIV)  div_reg  <= wr_cnt;
            if (addr == ADDR_PLEN) plen_reg <= wr_cnt;
        end
    end

    // Blink engine: a DIV write restarts the half-period with phase high on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (wr && (addr == ADDR_DIV)) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (div_reg == '0) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (bcnt == div_reg - CW'(1)) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt  <= bcnt + CW'(1);
        end
    end

    // Pulse engine: a retrigger takes priority over expiry of the running pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pmask <= '0;
            pcnt  <= '0;
        end else if (ptrig_fire) begin
            pmask <= wr_bits;
            pcnt  <= plen_reg;
        end else if (pulse_busy) begin
            pcnt <= pcnt - CW'(1);
            if (pcnt == CW'(1)) pmask <= '0;
        end
    end

    assign dout = (data_reg & (~mode_reg | {W{phase}})) | (pmask & {W{pulse_busy}});

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_DATA: rd_data = 32'(data_reg);
            ADDR_MODE: rd_data = 32'(mode_reg);
            ADDR_DIV:  rd_data = 32'(div_reg);
            ADDR_PLEN: rd_data = 32'(plen_reg);
            ADDR_STAT: rd_data = {30'd0, phase, pulse_busy};
            default:   rd_data = '0;
        endcase
    end

endmodule
